// File: rtl/fpu_op_sequencer_if.sv
// Command, FPU-side and response signals of the FPU op sequencer.
// The master modport is the sequencer's view; slave is the environment (producer, FPU, consumer).
interface fpu_op_sequencer_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  logic             fpu_start;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_op;
  logic             fpu_done;
  logic [31:0]      fpu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;

  logic             busy;
  logic [CNT_W-1:0] count;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  fpu_done, fpu_result,
    input  rsp_ready,
    output cmd_ready,
    output fpu_start, fpu_a, fpu_b, fpu_op,
    output rsp_valid, rsp_result, rsp_tag, rsp_timeout,
    output busy, count
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output fpu_done, fpu_result,
    output rsp_ready,
    input  cmd_ready,
    input  fpu_start, fpu_a, fpu_b, fpu_op,
    input  rsp_valid, rsp_result, rsp_tag, rsp_timeout,
    input  busy, count
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Queues single-precision FPU commands and issues them one at a time with a start pulse,
// returning each result (or a timeout NaN) with its tag in issue order.
module fpu_op_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input logic                clk,
  input logic                rst,
  fpu_op_sequencer_if.master bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [31:0] TIMEOUT_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  logic [31:0]      mem_a   [DEPTH];
  logic [31:0]      mem_b   [DEPTH];
  logic [1:0]       mem_op  [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             push;
  logic             pop;

  state_t           state;
  logic [WAIT_W-1:0] wait_cnt;
  logic             start_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_result_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_timeout_q;

  // Readiness comes from the registered count only, so a full FIFO refuses even when popping.
  assign full = (cnt == CNT_W'(DEPTH));
  assign push = bus.cmd_valid && !full;
  assign pop  = (state == S_IDLE) && (cnt != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= bus.cmd_a;
      mem_b[wr_ptr]   <= bus.cmd_b;
      mem_op[wr_ptr]  <= bus.cmd_op;
      mem_tag[wr_ptr] <= bus.cmd_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Operands stay registered from ISSUE through WAIT since the FPU samples them over many cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      start_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      tag_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_tag_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            a_q     <= mem_a[rd_ptr];
            b_q     <= mem_b[rd_ptr];
            op_q    <= mem_op[rd_ptr];
            tag_q   <= mem_tag[rd_ptr];
            start_q <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_q  <= 1'b0;
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the final allowed cycle beats the timeout.
          if (bus.fpu_done) begin
            rsp_result_q  <= bus.fpu_result;
            rsp_timeout_q <= 1'b0;
            rsp_tag_q     <= tag_q;
            rsp_valid_q   <= 1'b1;
            state         <= S_HOLD;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            rsp_result_q  <= TIMEOUT_NAN;
            rsp_timeout_q <= 1'b1;
            rsp_tag_q     <= tag_q;
            rsp_valid_q   <= 1'b1;
            state         <= S_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = !full;
  assign bus.fpu_start   = start_q;
  assign bus.fpu_a       = a_q;
  assign bus.fpu_b       = b_q;
  assign bus.fpu_op      = op_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_tag     = rsp_tag_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.busy        = (state != S_IDLE) || (cnt != '0);
  assign bus.count       = cnt;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: behavioural FPU model plus an in-order response scoreboard.
module tb_fpu_op_sequencer;
  localparam int DEPTH = 4, TAG_W = 4, TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_op_sequencer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
  fpu_op_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic             tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   start_seen = 0;

  // FPU model: done pulse lat cycles after the start is sampled; countdown frozen while stalled.
  logic        stall = 1'b0, use_fixed = 1'b0;
  logic [31:0] fixed_res = '0;
  int          lat = 2;
  logic        model_busy = 1'b0, model_done = 1'b0;
  logic [31:0] model_res = '0;
  int          rem = 0;
  logic        inj_done = 1'b0;
  logic [31:0] inj_res = '0;

  assign bus.fpu_done   = model_done | inj_done;
  assign bus.fpu_result = inj_done ? inj_res : model_res;

  always @(posedge clk) begin
    model_done <= 1'b0;
    if (bus.fpu_start) begin
      model_busy <= 1'b1;
      rem        <= lat - 1;
      model_res  <= use_fixed ? fixed_res : (bus.fpu_a ^ bus.fpu_b);
    end else if (model_busy && !stall) begin
      if (rem == 0) begin
        model_done <= 1'b1;
        model_busy <= 1'b0;
      end else begin
        rem <= rem - 1;
      end
    end
  end

  always @(negedge clk) if (bus.fpu_start) start_seen++;

  task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [TAG_W-1:0] tag, input logic [31:0] res, input logic tmo);
    int   k = 0;
    exp_t e;
    bus.cmd_valid = 1'b1; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_tag = tag;
    while (!bus.cmd_ready && k < 200) begin @(negedge clk); k++; end
    if (!bus.cmd_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL push_accept tag=%0d: cmd_ready=%b required 1 within 200 cycles", tag, bus.cmd_ready);
    end else begin
      @(posedge clk);
      e.tag = tag; e.res = res; e.tmo = tmo;
      exp_q.push_back(e);
    end
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget, output bit ok, output exp_t got);
    ok = 1'b0; got = '0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got.tag = bus.rsp_tag; got.res = bus.rsp_result; got.tmo = bus.rsp_timeout;
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.cmd_op = 0; bus.cmd_tag = 0; bus.rsp_ready = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b required 1", bus.cmd_ready); end
    n_cmp++; if ({bus.busy, bus.count} !== 4'b0) begin n_fail++; $display("FAIL reset_busy_count: got %b required 0", {bus.busy, bus.count}); end
    n_cmp++; if ({bus.fpu_start, bus.fpu_a, bus.fpu_b, bus.fpu_op} !== 67'b0) begin n_fail++; $display("FAIL reset_fpu_outputs: got %h required 0", {bus.fpu_start, bus.fpu_a, bus.fpu_b, bus.fpu_op}); end
    n_cmp++; if ({bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_timeout} !== 38'b0) begin n_fail++; $display("FAIL reset_rsp_outputs: got %h required 0", {bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_timeout}); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit ok; exp_t got, e; int s0;
    lat = 5; use_fixed = 1'b1; fixed_res = 32'h4040_0000;
    s0 = start_seen;
    push_cmd(32'h3F80_0000, 32'h4000_0000, 2'b00, 4'd3, 32'h4040_0000, 1'b0);
    @(negedge clk);
    n_cmp++; if (bus.fpu_start !== 1'b0) begin n_fail++; $display("FAIL single_start_early: got %b required 0", bus.fpu_start); end
    @(negedge clk);
    n_cmp++; if ({bus.fpu_start, bus.fpu_a, bus.fpu_b, bus.fpu_op} !== {1'b1, 32'h3F80_0000, 32'h4000_0000, 2'b00}) begin n_fail++; $display("FAIL single_issue: got %h required %h", {bus.fpu_start, bus.fpu_a, bus.fpu_b, bus.fpu_op}, {1'b1, 32'h3F80_0000, 32'h4000_0000, 2'b00}); end
    @(negedge clk);
    n_cmp++; if ({bus.fpu_start, bus.fpu_a, bus.fpu_b} !== {1'b0, 32'h3F80_0000, 32'h4000_0000}) begin n_fail++; $display("FAIL single_wait_hold: got %h required %h", {bus.fpu_start, bus.fpu_a, bus.fpu_b}, {1'b0, 32'h3F80_0000, 32'h4000_0000}); end
    wait_rsp(100, ok, got);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++; if (!ok || got !== e) begin n_fail++; $display("FAIL single_rsp: got ok=%b %h required %h", ok, got, e); end
    n_cmp++; if (start_seen - s0 !== 1) begin n_fail++; $display("FAIL single_start_count: got %0d required 1", start_seen - s0); end
    use_fixed = 1'b0;
  endtask

  task automatic test_full_order();
    lat = 2; stall = 1'b1;
    for (int t = 0; t < 5; t++)
      push_cmd(32'h1000_0000 + t, 32'h0000_0A00 * t, 2'(t), 4'(t), (32'h1000_0000 + t) ^ (32'h0000_0A00 * t), 1'b0);
    @(negedge clk);
    n_cmp++; if ({bus.count, bus.cmd_ready} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL full_count_ready: got %b required %b", {bus.count, bus.cmd_ready}, {3'd4, 1'b0}); end
    fork
      push_cmd(32'h1000_0005, 32'h0000_3200, 2'b01, 4'd5, 32'h1000_0005 ^ 32'h0000_3200, 1'b0);
      begin
        bit ok; exp_t got, e;
        repeat (6) @(negedge clk);
        n_cmp++; if ({bus.count, bus.cmd_ready} !== {3'd4, 1'b0} || exp_q.size() != 5) begin n_fail++; $display("FAIL full_no_accept: got count=%0d ready=%b queued=%0d required 4 0 5", bus.count, bus.cmd_ready, exp_q.size()); end
        stall = 1'b0;
        for (int t = 0; t < 6; t++) begin
          wait_rsp(100, ok, got);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          n_cmp++; if (!ok || got !== e) begin n_fail++; $display("FAIL order_rsp%0d: got ok=%b %h required %h", t, ok, got, e); end
        end
      end
    join
  endtask

  task automatic test_timeout();
    bit ok; exp_t got, e; int k;
    stall = 1'b1;
    push_cmd(32'h4120_0000, 32'h4130_0000, 2'b11, 4'd7, 32'h7FC0_0000, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.fpu_start && k < 10);
    repeat (TIMEOUT) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_early: rsp_valid=%b required 0 one cycle before limit", bus.rsp_valid); end
    @(posedge clk); @(negedge clk);
    got.tag = bus.rsp_tag; got.res = bus.rsp_result; got.tmo = bus.rsp_timeout;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++; if (bus.rsp_valid !== 1'b1 || got !== e) begin n_fail++; $display("FAIL timeout_rsp: got valid=%b %h required 1 %h", bus.rsp_valid, got, e); end
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    stall = 1'b0;
    repeat (4) @(posedge clk);
    #1 push_cmd(32'h3F00_0000, 32'h3E00_0000, 2'b10, 4'd8, 32'h3F00_0000 ^ 32'h3E00_0000, 1'b0);
    wait_rsp(100, ok, got);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++; if (!ok || got !== e) begin n_fail++; $display("FAIL after_timeout_rsp: got ok=%b %h required %h", ok, got, e); end
  endtask

  task automatic test_hold();
    bit ok; exp_t got, e, cur; int k, s0, bad;
    lat = 2; bus.rsp_ready = 1'b0;
    push_cmd(32'h0000_1111, 32'h2222_0000, 2'b00, 4'd9, 32'h2222_1111, 1'b0);
    push_cmd(32'h0F0F_0F0F, 32'h00FF_00FF, 2'b01, 4'd10, 32'h0FF0_0FF0, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.rsp_valid && k < 50);
    got.tag = bus.rsp_tag; got.res = bus.rsp_result; got.tmo = bus.rsp_timeout;
    s0 = start_seen; bad = 0;
    repeat (10) begin
      @(negedge clk);
      cur.tag = bus.rsp_tag; cur.res = bus.rsp_result; cur.tmo = bus.rsp_timeout;
      if (!bus.rsp_valid || cur !== got) bad++;
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles required 0", bad); end
    n_cmp++; if (start_seen != s0) begin n_fail++; $display("FAIL hold_no_start: got %0d starts required 0", start_seen - s0); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++; if (got !== e) begin n_fail++; $display("FAIL hold_rsp: got %h required %h", got, e); end
    bus.rsp_ready = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.fpu_start && k < 5);
    n_cmp++; if (!bus.fpu_start || k > 2) begin n_fail++; $display("FAIL hold_restart: start after %0d cycles required <=2", k); end
    wait_rsp(100, ok, got);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++; if (!ok || got !== e) begin n_fail++; $display("FAIL hold_second_rsp: got ok=%b %h required %h", ok, got, e); end
  endtask

  task automatic test_reset_mid();
    int bad;
    lat = 2; stall = 1'b1;
    for (int t = 1; t <= 4; t++) push_cmd(32'hA000_0000 + t, 32'h5, 2'b10, 4'(t), (32'hA000_0000 + t) ^ 32'h5, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.count !== 3'd3) begin n_fail++; $display("FAIL midrst_count_before: got %0d required 3", bus.count); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    inj_res = 32'h1234_5678; inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    bad = 0;
    repeat (8) begin @(negedge clk); if (bus.rsp_valid || bus.fpu_start) bad++; end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL midrst_no_activity: got %0d active cycles required 0", bad); end
    n_cmp++; if ({bus.count, bus.cmd_ready, bus.busy} !== {3'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL midrst_ctrl: got %b required %b", {bus.count, bus.cmd_ready, bus.busy}, {3'd0, 1'b1, 1'b0}); end
    n_cmp++; if ({bus.fpu_start, bus.fpu_a, bus.fpu_b, bus.fpu_op, bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_timeout} !== 105'b0) begin n_fail++; $display("FAIL midrst_outputs: got %h required 0", {bus.fpu_start, bus.fpu_a, bus.fpu_b, bus.fpu_op, bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_timeout}); end
    stall = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_done_vs_timeout();
    exp_t got, e; int k;
    stall = 1'b1;
    push_cmd(32'hC000_0000, 32'h4020_0000, 2'b10, 4'd5, 32'hC0A0_0000, 1'b0);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.fpu_start && k < 10);
    repeat (TIMEOUT) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL coincide_early: rsp_valid=%b required 0", bus.rsp_valid); end
    inj_res = 32'hC0A0_0000; inj_done = 1'b1;
    @(posedge clk); @(negedge clk);
    inj_done = 1'b0;
    got.tag = bus.rsp_tag; got.res = bus.rsp_result; got.tmo = bus.rsp_timeout;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    n_cmp++; if (bus.rsp_valid !== 1'b1 || got !== e) begin n_fail++; $display("FAIL coincide_rsp: got valid=%b %h required 1 %h", bus.rsp_valid, got, e); end
    @(posedge clk); #1;
    stall = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    lat = 3; stall = 1'b0;
    for (int t = 11; t < 14; t++) push_cmd(32'h0101_0000 * t, 32'h77, 2'(t), 4'(t), (32'h0101_0000 * t) ^ 32'h77, 1'b0);
    fork
      begin
        bit ok; exp_t got, e;
        for (int t = 0; t < 3; t++) begin
          wait_rsp(100, ok, got);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          n_cmp++; if (!ok || got !== e) begin n_fail++; $display("FAIL b2b_rsp%0d: got ok=%b %h required %h", t, ok, got, e); end
        end
      end
      begin
        int k, g;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.fpu_done && k < 100);
        g = 0;
        do begin @(negedge clk); g++; end while (!bus.fpu_start && g < 20);
        n_cmp++; if (g != 3) begin n_fail++; $display("FAIL b2b_done_to_start: got %0d cycles required 3", g); end
      end
    join
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_order();
    test_timeout();
    test_hold();
    test_reset_mid();
    test_done_vs_timeout();
    test_back_to_back();
    repeat (5) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL final_drain: got %0d pending busy=%b required 0 0", exp_q.size(), bus.busy); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
